// File: rtl/fnd_scan_ctrl.sv
// Four-digit common-anode 7-segment scan driver: time-multiplexes four digit
// codes onto active-low digit selects/segments with an optional blinking dp.
module fnd_scan_ctrl #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned SCAN_HZ  = 1000,
   parameter int unsigned BLINK_HZ = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] digit_1,
   input  logic [3:0] digit_10,
   input  logic [3:0] digit_100,
   input  logic [3:0] digit_1000,
   input  logic [3:0] dot_en,
   input  logic       dot_blink,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data
);

   localparam int unsigned SCAN_DIV  = CLK_FREQ / SCAN_HZ;
   localparam int unsigned BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
   localparam int unsigned SCAN_W    = $clog2(SCAN_DIV);
   localparam int unsigned BLINK_W   = $clog2(BLINK_DIV);

   logic [SCAN_W-1:0]  scan_cnt;
   logic [1:0]         scan_idx;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   logic               scan_tick;
   logic               blink_wrap;
   logic [3:0]         code;
   logic [6:0]         seg;
   logic               dp_n;

   assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

   always_comb begin
      code = '0;
      case (scan_idx)
         2'd0: code = digit_1;
         2'd1: code = digit_10;
         2'd2: code = digit_100;
         2'd3: code = digit_1000;
         default: code = '0;
      endcase
   end

   // Active-low g..a; 4'hE is the splitter's blank code, other non-decimal codes show a dash.
   always_comb begin
      seg = 7'h3F;
      case (code)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hE: seg = 7'h7F;
         default: seg = 7'h3F;
      endcase
   end

   assign dp_n = ~(dot_en[scan_idx] & (~dot_blink | blink_phase));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt    <= '0;
         scan_idx    <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         fnd_com     <= '1;
         fnd_data    <= '1;
      end else begin
         if (scan_tick) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end

         if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end

         fnd_com  <= ~(4'b0001 << scan_idx);
         fnd_data <= {dp_n, seg};
      end
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: scoreboard of per-cycle expected
// outputs plus scenario tasks checking the documented display values.
module tb_fnd_scan_ctrl;

   localparam int unsigned SCAN_DIV  = 10;
   localparam int unsigned BLINK_DIV = 50;

   logic       clk;
   logic       rst_n;
   logic [3:0] digit_1;
   logic [3:0] digit_10;
   logic [3:0] digit_100;
   logic [3:0] digit_1000;
   logic [3:0] dot_en;
   logic       dot_blink;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [11:0] sb[$];
   logic [3:0]  m_cnt   = '0;
   logic [1:0]  m_idx   = '0;
   logic [5:0]  m_bcnt  = '0;
   logic        m_ph    = 1'b0;

   logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F, 7'h3F};
   logic [7:0] sweep_exp [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                    8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hFF, 8'hBF};

   fnd_scan_ctrl #(
      .CLK_FREQ (100),
      .SCAN_HZ  (10),
      .BLINK_HZ (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digit_1    (digit_1),
      .digit_10   (digit_10),
      .digit_100  (digit_100),
      .digit_1000 (digit_1000),
      .dot_en     (dot_en),
      .dot_blink  (dot_blink),
      .fnd_com    (fnd_com),
      .fnd_data   (fnd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] sel_code(input logic [1:0] idx);
      case (idx)
         2'd0: return digit_1;
         2'd1: return digit_10;
         2'd2: return digit_100;
         default: return digit_1000;
      endcase
   endfunction

   // Reference timebase: each edge produces the output implied by the pre-edge state.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= '0;
         m_idx  <= '0;
         m_bcnt <= '0;
         m_ph   <= 1'b0;
         cyc    <= 0;
         sb.delete();
      end else begin
         sb.push_back({~(4'b0001 << m_idx),
                       !(dot_en[m_idx] && (!dot_blink || m_ph)),
                       seg_tab[sel_code(m_idx)]});
         cyc <= cyc + 1;
         if (m_cnt == 4'(SCAN_DIV - 1)) begin
            m_cnt <= '0;
            m_idx <= m_idx + 2'd1;
         end else begin
            m_cnt <= m_cnt + 4'd1;
         end
         if (m_bcnt == 6'(BLINK_DIV - 1)) begin
            m_bcnt <= '0;
            m_ph   <= !m_ph;
         end else begin
            m_bcnt <= m_bcnt + 6'd1;
         end
      end
   end

   always @(negedge clk) begin
      logic [11:0] exp;
      if (rst_n && cyc > 0) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: no expected entry at cycle %0d", cyc);
         end else begin
            exp = sb.pop_front();
            if ({fnd_com, fnd_data} !== exp) begin
               n_fail++;
               $display("FAIL sb_out: cycle %0d got com=%b data=%h expected com=%b data=%h",
                        cyc, fnd_com, fnd_data, exp[11:8], exp[7:0]);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      digit_1 = 4'd0; digit_10 = 4'd0; digit_100 = 4'd0; digit_1000 = 4'd0;
      dot_en = 4'b0000; dot_blink = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL reset_hold: got com=%b data=%h expected 1111/ff", fnd_com, fnd_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
         n_fail++;
         $display("FAIL reset_first: got com=%b data=%h expected 1110/c0", fnd_com, fnd_data);
      end
   endtask

   task automatic test_scan_order();
      logic [3:0] prev_com;
      int run;
      int pos;
      logic [7:0] exp_data;
      digit_1000 = 4'd1; digit_100 = 4'd2; digit_10 = 4'd3; digit_1 = 4'd4;
      prev_com = fnd_com;
      run = 1;
      for (int i = 0; i < 52; i++) begin
         @(negedge clk);
         pos = ((cyc - 1) / SCAN_DIV) % 4;
         case (pos)
            0: exp_data = 8'h99;
            1: exp_data = 8'hB0;
            2: exp_data = 8'hA4;
            default: exp_data = 8'hF9;
         endcase
         n_checks++;
         if (fnd_com !== ~(4'b0001 << pos) || fnd_data !== exp_data) begin
            n_fail++;
            $display("FAIL scan_pos: cycle %0d got com=%b data=%h expected com=%b data=%h",
                     cyc, fnd_com, fnd_data, ~(4'b0001 << pos), exp_data);
         end
         if (fnd_com !== prev_com) begin
            n_checks++;
            if (fnd_com !== {prev_com[2:0], prev_com[3]}) begin
               n_fail++;
               $display("FAIL scan_seq: got com=%b after %b expected %b",
                        fnd_com, prev_com, {prev_com[2:0], prev_com[3]});
            end
            if (cyc > 12) begin
               n_checks++;
               if (run != SCAN_DIV) begin
                  n_fail++;
                  $display("FAIL scan_dwell: com=%b held %0d cycles expected %0d", prev_com, run, SCAN_DIV);
               end
            end
            run = 1;
            prev_com = fnd_com;
         end else begin
            run++;
         end
      end
   endtask

   task automatic test_decode_sweep();
      digit_10 = 4'd0; digit_100 = 4'd0; digit_1000 = 4'd0;
      dot_en = 4'b0000;
      for (int c = 0; c < 16; c++) begin
         for (int w = 0; w < 50 && ((cyc / SCAN_DIV) % 4) != 0; w++) @(negedge clk);
         digit_1 = 4'(c);
         @(negedge clk);
         n_checks++;
         if (fnd_com !== 4'b1110 || fnd_data !== sweep_exp[c]) begin
            n_fail++;
            $display("FAIL decode_%0d: got com=%b data=%h expected 1110/%h",
                     c, fnd_com, fnd_data, sweep_exp[c]);
         end
      end
   endtask

   task automatic test_blank();
      digit_1 = 4'd7; digit_10 = 4'hE;
      dot_en = 4'b0010; dot_blink = 1'b0;
      for (int w = 0; w < 50 && ((cyc / SCAN_DIV) % 4) != 1; w++) @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (fnd_com !== 4'b1101 || fnd_data !== 8'h7F) begin
         n_fail++;
         $display("FAIL blank_dp: got com=%b data=%h expected 1101/7f", fnd_com, fnd_data);
      end
   endtask

   task automatic test_blink();
      bit seen_off = 0;
      bit seen_on  = 0;
      logic [7:0] exp_data;
      digit_100 = 4'd5; dot_en = 4'b0100; dot_blink = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 240; i++) begin
         @(negedge clk);
         if (fnd_com == 4'b1011) begin
            exp_data = ((((cyc - 1) / BLINK_DIV) % 2) != 0) ? 8'h12 : 8'h92;
            if (exp_data == 8'h12) seen_on = 1; else seen_off = 1;
            n_checks++;
            if (fnd_data !== exp_data) begin
               n_fail++;
               $display("FAIL blink_dp: cycle %0d got data=%h expected %h", cyc, fnd_data, exp_data);
            end
         end
      end
      n_checks++;
      if (!(seen_on && seen_off)) begin
         n_fail++;
         $display("FAIL blink_phases: seen lit=%0d unlit=%0d expected both 1", seen_on, seen_off);
      end
   endtask

   task automatic test_mid_reset();
      for (int w = 0; w < 50 && (((cyc - 1) / SCAN_DIV) % 4) != 2; w++) @(negedge clk);
      n_checks++;
      if (fnd_com !== 4'b1011) begin
         n_fail++;
         $display("FAIL midrst_pre: got com=%b expected 1011", fnd_com);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL midrst_async: got com=%b data=%h expected 1111/ff", fnd_com, fnd_data);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL midrst_hold: got com=%b data=%h expected 1111/ff", fnd_com, fnd_data);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < SCAN_DIV; i++) begin
         @(negedge clk);
         n_checks++;
         if (fnd_com !== 4'b1110) begin
            n_fail++;
            $display("FAIL midrst_dwell: cycle %0d got com=%b expected 1110", i + 1, fnd_com);
         end
      end
      @(negedge clk);
      n_checks++;
      if (fnd_com !== 4'b1101) begin
         n_fail++;
         $display("FAIL midrst_next: got com=%b expected 1101", fnd_com);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_scan_order();
      test_decode_sweep();
      test_blank();
      test_blink();
      test_mid_reset();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
